// File: rtl/neureka_tcdm_splitter_pkg.sv
// Shared constants for the wide-to-narrow TCDM splitter.
package neureka_tcdm_splitter_pkg;

   localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 288;
   localparam int unsigned NEUREKA_SPLIT_MP          = NEUREKA_MEM_BANDWIDTH_EXT / 32;
   localparam int unsigned NEUREKA_SPLIT_RESP_DEPTH  = 2;
   localparam int unsigned NEUREKA_SPLIT_AW          = 32;

endpackage

// File: rtl/neureka_tcdm_splitter_if.sv
// Wide HCI initiator side plus the MP narrow TCDM ports of the splitter.
interface neureka_tcdm_splitter_if #(
   parameter int unsigned MP = 9,
   parameter int unsigned AW = 32
);
   logic             req_i;
   logic             gnt_o;
   logic [AW-1:0]    add_i;
   logic             wen_i;
   logic [MP*4-1:0]  be_i;
   logic [MP*32-1:0] data_i;
   logic             r_valid_o;
   logic             r_ready_i;
   logic [MP*32-1:0] r_data_o;

   logic [MP-1:0]    tcdm_req_o;
   logic [MP-1:0]    tcdm_gnt_i;
   logic [MP*AW-1:0] tcdm_add_o;
   logic [MP-1:0]    tcdm_wen_o;
   logic [MP*4-1:0]  tcdm_be_o;
   logic [MP*32-1:0] tcdm_data_o;
   logic [MP-1:0]    tcdm_r_valid_i;
   logic [MP*32-1:0] tcdm_r_data_i;

   modport slave (
      input  req_i, add_i, wen_i, be_i, data_i, r_ready_i,
      input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i,
      output gnt_o, r_valid_o, r_data_o,
      output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o
   );

   modport master (
      output req_i, add_i, wen_i, be_i, data_i, r_ready_i,
      output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i,
      input  gnt_o, r_valid_o, r_data_o,
      input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o
   );

endinterface

// File: rtl/neureka_split_resp_fifo.sv
// Per-port read response FIFO; registered head, push allowed while full if popping.
module neureka_split_resp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [DW-1:0] head_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_push, w_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (r_cnt == CW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign w_pop   = pop_i & ~empty_o;
   assign w_push  = push_i & (~full_o | w_pop);
   assign head_o  = r_mem[r_rptr];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (clear_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= next_ptr(r_wptr);
         if (w_pop)  r_rptr <= next_ptr(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= push_data_i;
   end

endmodule

// File: rtl/neureka_tcdm_splitter.sv
// Splits a wide HCI request into MP independent 32-bit TCDM ports and reassembles the
// read responses, so ports may be granted and answer on different cycles.
module neureka_tcdm_splitter
   import neureka_tcdm_splitter_pkg::*;
#(
   parameter int unsigned MP           = NEUREKA_SPLIT_MP,
   parameter int unsigned AW           = NEUREKA_SPLIT_AW,
   parameter int unsigned RESP_DEPTH   = NEUREKA_SPLIT_RESP_DEPTH,
   parameter bit          SKIP_ZERO_BE = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   neureka_tcdm_splitter_if.slave bus,
   output logic                   busy_o,
   output logic                   err_o
);
   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

   logic [MP-1:0]    r_done;
   logic             r_err;
   logic [MP-1:0]    w_skip, w_req, w_fin, w_rd_gnt, w_spur, w_push;
   logic [MP-1:0]    w_empty, w_full, w_cred_nz;
   logic [MP*32-1:0] w_head;
   logic             w_hold, w_gnt, w_rvalid, w_pop;

   // Outputs are forced quiet while reset or clear is active so nothing is accepted then.
   assign w_hold   = rst_i | clear_i;
   assign w_gnt    = bus.req_i & ~w_hold & (&w_fin);
   assign w_rvalid = ~|w_empty;
   assign w_pop    = w_rvalid & bus.r_ready_i;

   assign bus.gnt_o     = w_gnt;
   assign bus.r_valid_o = w_rvalid;
   assign bus.r_data_o  = w_rvalid ? w_head : '0;
   assign busy_o        = (|r_done) | (|w_cred_nz);
   assign err_o         = r_err;

   for (genvar ii = 0; ii < MP; ii++) begin : g_port
      logic [CW-1:0] r_cred;

      assign w_skip[ii]    = SKIP_ZERO_BE & ~bus.wen_i & (bus.be_i[4*ii +: 4] == 4'b0);
      assign w_req[ii]     = bus.req_i & ~w_hold & ~r_done[ii] & ~w_skip[ii]
                             & (~bus.wen_i | (r_cred < CW'(RESP_DEPTH)));
      assign w_fin[ii]     = r_done[ii] | w_skip[ii] | (w_req[ii] & bus.tcdm_gnt_i[ii]);
      assign w_rd_gnt[ii]  = w_req[ii] & bus.tcdm_gnt_i[ii] & bus.wen_i;
      assign w_spur[ii]    = bus.tcdm_r_valid_i[ii] & (r_cred == '0);
      assign w_push[ii]    = bus.tcdm_r_valid_i[ii] & ~w_spur[ii] & (~w_full[ii] | w_pop);
      assign w_cred_nz[ii] = (r_cred != '0);

      assign bus.tcdm_req_o[ii]            = w_req[ii];
      assign bus.tcdm_add_o[AW*ii +: AW]   = w_req[ii] ? bus.add_i + AW'(4 * ii) : '0;
      assign bus.tcdm_wen_o[ii]            = w_req[ii] & bus.wen_i;
      assign bus.tcdm_be_o[4*ii +: 4]      = w_req[ii] ? bus.be_i[4*ii +: 4] : '0;
      assign bus.tcdm_data_o[32*ii +: 32]  = w_req[ii] ? bus.data_i[32*ii +: 32] : '0;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_cred <= '0;
         end else if (clear_i) begin
            r_cred <= '0;
         end else if (w_rd_gnt[ii] & ~w_pop) begin
            r_cred <= r_cred + CW'(1);
         end else if (~w_rd_gnt[ii] & w_pop) begin
            r_cred <= r_cred - CW'(1);
         end
      end

      neureka_split_resp_fifo #(
         .DEPTH (RESP_DEPTH),
         .DW    (32)
      ) i_fifo (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .clear_i     (clear_i),
         .push_i      (w_push[ii]),
         .push_data_i (bus.tcdm_r_data_i[32*ii +: 32]),
         .pop_i       (w_pop),
         .full_o      (w_full[ii]),
         .empty_o     (w_empty[ii]),
         .head_o      (w_head[32*ii +: 32])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_done <= '0;
      end else if (clear_i) begin
         r_done <= '0;
      end else if (w_gnt) begin
         r_done <= '0;
      end else if (bus.req_i) begin
         r_done <= w_fin;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if (clear_i) begin
         r_err <= 1'b0;
      end else if (|w_spur) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_neureka_tcdm_splitter.sv
// Directed bench: read data goes through a scoreboard queue popped by a monitor,
// handshake and status outputs are checked inline.
module tb_neureka_tcdm_splitter;
   localparam int unsigned MP = 9;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = MP * 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          req = 1'b0;
   logic          req2 = 1'b0;
   logic          wen = 1'b0;
   logic          r_ready = 1'b1;
   logic          resp_en = 1'b1;
   logic [AW-1:0] add = '0;
   logic [MP*4-1:0] be = '1;
   logic [DW-1:0] wdata = '0;
   logic [MP-1:0] gnt_mask = '0;
   logic [MP-1:0] spur = '0;
   logic [MP-1:0] r_pend;
   logic [DW-1:0] r_pdata;
   logic          busy, err, busy2, err2;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   neureka_tcdm_splitter_if #(.MP(MP), .AW(AW)) bif ();
   neureka_tcdm_splitter_if #(.MP(MP), .AW(AW)) bif2 ();

   assign bif.req_i          = req;
   assign bif.add_i          = add;
   assign bif.wen_i          = wen;
   assign bif.be_i           = be;
   assign bif.data_i         = wdata;
   assign bif.r_ready_i      = r_ready;
   assign bif.tcdm_gnt_i     = gnt_mask;
   assign bif.tcdm_r_valid_i = r_pend | spur;
   assign bif.tcdm_r_data_i  = r_pdata;

   assign bif2.req_i          = req2;
   assign bif2.add_i          = add;
   assign bif2.wen_i          = wen;
   assign bif2.be_i           = be;
   assign bif2.data_i         = wdata;
   assign bif2.r_ready_i      = 1'b1;
   assign bif2.tcdm_gnt_i     = '1;
   assign bif2.tcdm_r_valid_i = '0;
   assign bif2.tcdm_r_data_i  = '0;

   neureka_tcdm_splitter #(
      .MP(MP), .AW(AW), .RESP_DEPTH(2), .SKIP_ZERO_BE(1'b1)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bif), .busy_o(busy), .err_o(err)
   );

   neureka_tcdm_splitter #(
      .MP(MP), .AW(AW), .RESP_DEPTH(2), .SKIP_ZERO_BE(1'b0)
   ) u_dut_ns (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bif2), .busy_o(busy2), .err_o(err2)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [DW-1:0] exp_wide(input logic [31:0] base);
      logic [DW-1:0] v;
      for (int ii = 0; ii < MP; ii++) v[32*ii +: 32] = mem_rd(base + 32'(4 * ii));
      return v;
   endfunction

   // TCDM model: every granted read answers exactly one cycle later
   always @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         for (int ii = 0; ii < MP; ii++) begin
            r_pend[ii] <= bif.tcdm_req_o[ii] & bif.tcdm_gnt_i[ii] & bif.tcdm_wen_o[ii] & resp_en;
            r_pdata[32*ii +: 32] <= mem_rd(bif.tcdm_add_o[AW*ii +: AW]);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bif.r_valid_o && bif.r_ready_i) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rdata_unexpected: got %h, required no response", bif.r_data_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bif.r_data_o !== mon_exp) begin
               n_err++;
               $display("FAIL rdata: got %h, required %h", bif.r_data_o, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_gnt", bif.gnt_o, 0);
      chk("rst_rvalid", bif.r_valid_o, 0);
      chk("rst_tcdm_req", bif.tcdm_req_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      step();
      rst = 1'b0;

      // All ports granted in the same cycle
      step();
      req = 1'b1; wen = 1'b1; add = 32'h1000; be = '1; gnt_mask = '1;
      #1;
      chk("t1_tcdm_req", bif.tcdm_req_o, 9'h1FF);
      chk("t1_gnt", bif.gnt_o, 1);
      for (int ii = 0; ii < MP; ii++)
         chk("t1_add", bif.tcdm_add_o[AW*ii +: AW], 32'h1000 + 32'(4 * ii));
      exp_q.push_back(exp_wide(32'h1000));
      step();
      req = 1'b0;
      #1;
      chk("t1_rvalid_early", bif.r_valid_o, 0);
      chk("t1_busy", busy, 1);
      step();
      #1;
      chk("t1_rvalid", bif.r_valid_o, 1);
      step();
      #1;
      chk("t1_idle", busy, 0);

      // Staggered write: port 3 granted four cycles late
      step();
      req = 1'b1; wen = 1'b0; add = 32'h2000; wdata = {MP{32'hA5A5_5A5A}}; gnt_mask = 9'h1F7;
      #1;
      chk("t2_req_first", bif.tcdm_req_o, 9'h1FF);
      chk("t2_gnt_first", bif.gnt_o, 0);
      chk("t2_wdata", bif.tcdm_data_o[127:96], 32'hA5A5_5A5A);
      for (int k = 1; k < 4; k++) begin
         step();
         #1;
         chk("t2_req_wait", bif.tcdm_req_o, 9'h008);
         chk("t2_gnt_wait", bif.gnt_o, 0);
      end
      step();
      gnt_mask = 9'h1FF;
      #1;
      chk("t2_req_last", bif.tcdm_req_o, 9'h008);
      chk("t2_gnt_last", bif.gnt_o, 1);
      step();
      req = 1'b0;
      #1;
      chk("t2_done_clear", busy, 0);

      // Credit limit: two reads accepted, third waits for a pop
      step();
      req = 1'b1; wen = 1'b1; add = 32'h3000; r_ready = 1'b0; gnt_mask = '1;
      #1;
      chk("t3_gnt_a", bif.gnt_o, 1);
      exp_q.push_back(exp_wide(32'h3000));
      step();
      add = 32'h3024;
      #1;
      chk("t3_gnt_b", bif.gnt_o, 1);
      exp_q.push_back(exp_wide(32'h3024));
      step();
      add = 32'h3048;
      #1;
      chk("t3_req_blocked", bif.tcdm_req_o, 0);
      chk("t3_gnt_blocked", bif.gnt_o, 0);
      step();
      #1;
      chk("t3_req_blocked2", bif.tcdm_req_o, 0);
      chk("t3_rvalid_full", bif.r_valid_o, 1);
      r_ready = 1'b1;
      step();
      #1;
      chk("t3_req_after_pop", bif.tcdm_req_o, 9'h1FF);
      chk("t3_gnt_c", bif.gnt_o, 1);
      exp_q.push_back(exp_wide(32'h3048));
      step();
      req = 1'b0;
      repeat (4) step();

      // Zero byte-enable slice skipped; address wrap
      req = 1'b1; req2 = 1'b1; wen = 1'b0; add = 32'hFFFF_FFF0; be = '1; be[23:20] = 4'h0;
      #1;
      chk("t4_req_skip", bif.tcdm_req_o, 9'h1DF);
      chk("t4_gnt", bif.gnt_o, 1);
      chk("t4_add_wrap4", bif.tcdm_add_o[AW*4 +: AW], 32'h0000_0000);
      chk("t4_add_wrap8", bif.tcdm_add_o[AW*8 +: AW], 32'h0000_0010);
      chk("t4_ns_req", bif2.tcdm_req_o, 9'h1FF);
      chk("t4_ns_be5", bif2.tcdm_be_o[23:20], 0);
      chk("t4_ns_gnt", bif2.gnt_o, 1);
      step();
      req = 1'b0; req2 = 1'b0; be = '1;

      // Spurious response on port 2
      step();
      spur = 9'h004;
      #1;
      chk("t5_err_pre", err, 0);
      step();
      spur = '0;
      #1;
      chk("t5_err_set", err, 1);
      chk("t5_busy", busy, 0);
      chk("t5_rvalid", bif.r_valid_o, 0);
      repeat (3) step();
      #1;
      chk("t5_err_sticky", err, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      #1;
      chk("t5_err_clear", err, 0);
      req = 1'b1; wen = 1'b1; add = 32'h4000;
      #1;
      chk("t5_gnt_read", bif.gnt_o, 1);
      exp_q.push_back(exp_wide(32'h4000));
      step();
      req = 1'b0;
      repeat (3) step();

      // Async reset mid-transaction
      req = 1'b1; wen = 1'b1; add = 32'h5000; resp_en = 1'b0; gnt_mask = '1;
      #1;
      chk("t6_gnt_a", bif.gnt_o, 1);
      step();
      add = 32'h5024; gnt_mask = 9'h00F;
      #1;
      chk("t6_gnt_partial", bif.gnt_o, 0);
      step();
      #1;
      chk("t6_req_rest", bif.tcdm_req_o, 9'h1F0);
      chk("t6_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_req", bif.tcdm_req_o, 0);
      chk("t6_rst_gnt", bif.gnt_o, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_rvalid", bif.r_valid_o, 0);
      chk("t6_rst_err", err, 0);
      step();
      rst = 1'b0; gnt_mask = '1; resp_en = 1'b1; add = 32'h6000;
      #1;
      chk("t6_req_all", bif.tcdm_req_o, 9'h1FF);
      chk("t6_gnt", bif.gnt_o, 1);
      exp_q.push_back(exp_wide(32'h6000));
      step();
      req = 1'b0;
      repeat (4) step();
      chk("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/neureka_tcdm_splitter.md
Name: neureka_tcdm_splitter

Overview:
- Splits one wide HCI-style initiator request (MP×32 bit) into MP independent 32-bit TCDM initiator ports.
- Each port completes its grant on its own; the wide grant is returned only when all ports are done.
- Reassembles read responses that arrive on different cycles, using per-port response FIFOs with credit-based flow control.
- Sits between the neureka streamer/engine HCI port and the cluster TCDM interconnect. Replaces the all-ports-same-cycle grant/valid assumption.

Parameters:
- MP, 9, number of 32-bit memory ports.
- AW, 32, address width.
- RESP_DEPTH, 2, per-port response FIFO depth; equals the maximum outstanding reads per port (≥1).
- SKIP_ZERO_BE, 1, when 1, store slices with all-zero byte enable are completed without issuing a port request.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear
- req_i  in  1  wide request valid
- gnt_o  out  1  wide request accepted
- add_i  in  AW  wide base address, word aligned
- wen_i  in  1  1=read, 0=write
- be_i  in  MP*4  byte enables, slice ii = bits [4ii+3:4ii]
- data_i  in  MP*32  write data, slice ii = port ii
- r_valid_o  out  1  wide read response valid
- r_ready_i  in  1  wide read response accepted
- r_data_o  out  MP*32  wide read data
- tcdm_req_o  out  MP  per-port request
- tcdm_gnt_i  in  MP  per-port grant
- tcdm_add_o  out  MP*AW  per-port address
- tcdm_wen_o  out  MP  per-port wen
- tcdm_be_o  out  MP*4  per-port byte enable
- tcdm_data_o  out  MP*32  per-port write data
- tcdm_r_valid_i  in  MP  per-port read valid
- tcdm_r_data_i  in  MP*32  per-port read data
- busy_o  out  1  a wide transaction is partially issued or reads are outstanding
- err_o  out  1  sticky: r_valid on a port with zero credits in use

Behaviour:
- Reset (rst_i=1, async): done mask=0, all FIFOs empty, all credit counters=0, err_o=0. All outputs 0, including gnt_o, r_valid_o, tcdm_req_o and busy_o. clear_i=1 has the same effect synchronously and takes priority over every same-cycle event.
- Upstream rule: req_i and its payload stay stable from assertion until gnt_o.
- Per-port issue (combinational): tcdm_req_o[ii] = req_i & ~done[ii] & ~skip[ii] & (wen_i ? cred[ii] < RESP_DEPTH : 1).
  - skip[ii] = SKIP_ZERO_BE & ~wen_i & (be slice ii == 0).
  - tcdm_add_o[ii] = add_i + 4*ii, modulo 2^AW (wraps).
  - wen, be and data are passed through per slice.
- Port completion this cycle: fin[ii] = done[ii] | skip[ii] | (tcdm_req_o[ii] & tcdm_gnt_i[ii]).
- gnt_o = req_i & (&fin). It can assert in the same cycle as the last port grant (zero added latency).
- Done mask: on gnt_o, done←0. Otherwise done[ii]←fin[ii] while req_i=1.
- Credits: cred[ii] increments on a granted read and decrements on a wide pop. A simultaneous increment and decrement leaves it unchanged. Width is $clog2(RESP_DEPTH+1).
- FIFOs: a FIFO pushes on tcdm_r_valid_i[ii]. Because credits bound pushes, a FIFO never overflows.
- err_o: set if tcdm_r_valid_i[ii] arrives while cred[ii]==0 (spurious response). That push is dropped. err_o clears only on rst_i or clear_i.
- Writes produce no upstream response, and any r_valid on a port carrying no read credit is treated as spurious.
- r_valid_o = all MP FIFOs non-empty. r_data_o = concatenation of the MP FIFO heads.
  - Pop all FIFOs when r_valid_o & r_ready_i.
  - Latency: r_valid_o rises the cycle after the last port's tcdm_r_valid_i (FIFO registered, no bypass).
  - The FIFO supports simultaneous push and pop when full.
- Ordering: per-port TCDM responses are in order, so FIFO heads always belong to the same wide transaction.
- busy_o = |done | (|cred).

Decomposition:
- neureka_package gains NEUREKA_SPLIT_RESP_DEPTH (default 2) and NEUREKA_SPLIT_MP = NEUREKA_MEM_BANDWIDTH_EXT/32.
- One sub-module, neureka_split_resp_fifo: 32-bit data, depth RESP_DEPTH, ports push/pop/full/empty/head, async active-high reset plus clear. It is instantiated MP times in a generate loop.

Test Plan:
- All MP ports grant in the same cycle, read at add 0x1000 → gnt_o in that cycle. Port addresses are 0x1000..0x1020. Responses arrive 1 cycle later, so r_valid_o appears 2 cycles after the request, with data in the correct slices.
- Staggered grants (port 3 granted 4 cycles late), write → ports 0-2,4-8 drop req after their grant. gnt_o fires in port 3's grant cycle only. The done mask is 0 afterwards.
- RESP_DEPTH=2, r_ready_i=0, three back-to-back reads → two wide grants. The third wide request shows tcdm_req_o=0 until one pop, then issues.
- Write with be slice 5 = 0 and SKIP_ZERO_BE=1 → tcdm_req_o[5] never asserts and gnt_o still fires. With SKIP_ZERO_BE=0, port 5 issues with be=0.
- Spurious tcdm_r_valid_i[2] with no reads outstanding → err_o=1 (sticky) and FIFO 2 stays empty. clear_i clears err_o.
- rst_i pulsed mid-transaction with the done mask partially set and 1 read outstanding → all outputs 0 immediately (async). The next request issues on all ports.
